// File: rtl/conv_mem_arbiter_pkg.sv
// Shared types and defaults for the conv1d accelerator memory path.
// Owner and response-pipe encodings plus widths common to the control unit.
package conv_pkg;

   typedef enum logic {OWNER_HOST, OWNER_ACC} owner_t;
   typedef enum logic {RESP_IDLE, RESP_RD} resp_state_t;

   localparam int CONFLICT_W = 16;
   localparam int WAIT_W     = 8;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 32;

   // Saturating increment for the conflict counter.
   function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] v);
      return (v == {CONFLICT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/conv_mem_arbiter_if.sv
// Bundle of the host port, accelerator port, SRAM port and conflict counter.
// The arbiter uses the slave view; requesters/SRAM model use the master view.
interface conv_mem_arbiter_if
   import conv_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_W-1:0]     host_addr;
   logic [DATA_W-1:0]     host_wdata;
   logic                  host_gnt;
   logic                  host_rvalid;
   logic [DATA_W-1:0]     host_rdata;

   logic                  acc_req;
   logic                  acc_we;
   logic [ADDR_W-1:0]     acc_addr;
   logic [DATA_W-1:0]     acc_wdata;
   logic                  acc_lock;
   logic                  acc_gnt;
   logic                  acc_rvalid;
   logic [DATA_W-1:0]     acc_rdata;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   logic [CONFLICT_W-1:0] conflict_cnt;

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      input  acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
      output acc_gnt, acc_rvalid, acc_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output conflict_cnt
   );

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      output acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
      input  acc_gnt, acc_rvalid, acc_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  conflict_cnt
   );

endinterface

// File: rtl/conv_mem_arbiter_resp.sv
// Per-port read-response pipe: rvalid one cycle after a granted read, rdata gated.
// A fresh read grant while a response is out simply re-enters RESP_RD.
module conv_arb_resp
   import conv_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gnt,
   input  logic              we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   resp_state_t state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESP_IDLE;
      end else begin
         case (state)
            RESP_IDLE: state <= (gnt && !we) ? RESP_RD : RESP_IDLE;
            RESP_RD:   state <= (gnt && !we) ? RESP_RD : RESP_IDLE;
            default:   state <= RESP_IDLE;
         endcase
      end
   end

   assign rvalid = (state == RESP_RD);
   assign rdata  = rvalid ? mem_rdata : '0;

endmodule

// File: rtl/conv_mem_arbiter.sv
// Per-cycle arbiter sharing the conv1d data SRAM between host and accelerator.
// Round-robin with accelerator burst lock and a host starvation guard; grants are combinational.
module conv_mem_arbiter
   import conv_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   conv_mem_arbiter_if.slave  bus
);

   owner_t                last_owner;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [CONFLICT_W-1:0] conflict_q;

   logic                  starve;
   logic                  both_req;
   logic                  host_gnt;
   logic                  acc_gnt;

   logic                  mux_we;
   logic [ADDR_W-1:0]     mux_addr;
   logic [DATA_W-1:0]     mux_wdata;

   assign starve   = bus.host_req && (wait_cnt == WAIT_W'(MAX_WAIT));
   assign both_req = bus.host_req && bus.acc_req;

   // Priority: starvation guard, then burst lock, then lone requester, then round-robin.
   always_comb begin
      host_gnt = 1'b0;
      acc_gnt  = 1'b0;
      if (starve) begin
         host_gnt = 1'b1;
      end else if (bus.acc_lock && bus.acc_req) begin
         acc_gnt = 1'b1;
      end else if (both_req) begin
         if (last_owner == OWNER_HOST) acc_gnt  = 1'b1;
         else                          host_gnt = 1'b1;
      end else begin
         host_gnt = bus.host_req;
         acc_gnt  = bus.acc_req;
      end
   end

   always_comb begin
      mux_we    = 1'b0;
      mux_addr  = '0;
      mux_wdata = '0;
      if (host_gnt) begin
         mux_we    = bus.host_we;
         mux_addr  = bus.host_addr;
         mux_wdata = bus.host_wdata;
      end else if (acc_gnt) begin
         mux_we    = bus.acc_we;
         mux_addr  = bus.acc_addr;
         mux_wdata = bus.acc_wdata;
      end
   end

   assign bus.host_gnt     = host_gnt;
   assign bus.acc_gnt      = acc_gnt;
   assign bus.mem_req      = host_gnt | acc_gnt;
   assign bus.mem_we       = mux_we;
   assign bus.mem_addr     = mux_addr;
   assign bus.mem_wdata    = mux_wdata;
   assign bus.conflict_cnt = conflict_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner <= OWNER_HOST;
         wait_cnt   <= '0;
         conflict_q <= '0;
      end else begin
         if (host_gnt)     last_owner <= OWNER_HOST;
         else if (acc_gnt) last_owner <= OWNER_ACC;

         // A withdrawn host request forgets how long it had been waiting.
         if (!bus.host_req || host_gnt)
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_W'(MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;

         if (both_req)
            conflict_q <= sat_inc(conflict_q);
      end
   end

   conv_arb_resp #(.DATA_W(DATA_W)) u_host_resp (
      .clk       (clk),
      .rst       (rst),
      .gnt       (host_gnt),
      .we        (bus.host_we),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.host_rvalid),
      .rdata     (bus.host_rdata)
   );

   conv_arb_resp #(.DATA_W(DATA_W)) u_acc_resp (
      .clk       (clk),
      .rst       (rst),
      .gnt       (acc_gnt),
      .we        (bus.acc_we),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (bus.acc_rvalid),
      .rdata     (bus.acc_rdata)
   );

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Randomized + directed bench for conv_mem_arbiter with an in-bench arbitration/SRAM model.
module tb_conv_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MW = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   conv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [31:0] pat(input int a);
      logic [7:0] b;
      b = 8'(a);
      if (a == 16) return 32'hDEADBEEF;
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   // SRAM macro: registered read, write on mem_we.
   logic [DW-1:0] sram [256];
   bit            sram_ready = 0;
   always @(posedge clk) begin
      if (!sram_ready) begin
         for (int i = 0; i < 256; i++) sram[i] <= pat(i);
         sram_ready <= 1;
      end else if (bus.mem_req) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata      <= sram[bus.mem_addr];
      end
   end

   // Reference model: state as of the last rising edge, checked every falling edge.
   initial begin
      logic [DW-1:0] shadow [256];
      bit  m_last_host, m_hv, m_av, eh, ea, e_we;
      int  m_wait, m_cnt, e_addr;
      logic [DW-1:0] m_hd, m_ad, e_wd;
      for (int i = 0; i < 256; i++) shadow[i] = pat(i);
      m_last_host = 1; m_hv = 0; m_av = 0; m_wait = 0; m_cnt = 0; m_hd = 0; m_ad = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_host_rvalid", bus.host_rvalid, 0);
            chk("rst_acc_rvalid", bus.acc_rvalid, 0);
            chk("rst_conflict", bus.conflict_cnt, 0);
            if (!bus.host_req && !bus.acc_req) begin
               chk("rst_gnt", {bus.host_gnt, bus.acc_gnt, bus.mem_req}, 0);
            end
            m_last_host = 1; m_hv = 0; m_av = 0; m_wait = 0; m_cnt = 0;
         end else begin
            eh = 0; ea = 0;
            if (bus.host_req && m_wait == MW)            eh = 1;
            else if (bus.acc_lock && bus.acc_req)        ea = 1;
            else if (bus.host_req && bus.acc_req)        begin ea = m_last_host; eh = !m_last_host; end
            else                                         begin eh = bus.host_req; ea = bus.acc_req; end
            e_we = eh ? bus.host_we : ea ? bus.acc_we : 1'b0;
            e_addr = eh ? int'(bus.host_addr) : ea ? int'(bus.acc_addr) : 0;
            e_wd = eh ? bus.host_wdata : ea ? bus.acc_wdata : '0;

            chk("host_gnt", bus.host_gnt, eh);
            chk("acc_gnt", bus.acc_gnt, ea);
            chk("mem_req", bus.mem_req, eh | ea);
            chk("mem_we", bus.mem_we, e_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("host_rvalid", bus.host_rvalid, m_hv);
            chk("host_rdata", bus.host_rdata, m_hv ? m_hd : 0);
            chk("acc_rvalid", bus.acc_rvalid, m_av);
            chk("acc_rdata", bus.acc_rdata, m_av ? m_ad : 0);
            chk("conflict_cnt", bus.conflict_cnt, m_cnt);

            m_hv = eh && !e_we;
            m_av = ea && !e_we;
            if (m_hv) m_hd = shadow[e_addr];
            if (m_av) m_ad = shadow[e_addr];
            if ((eh | ea) && e_we) shadow[e_addr] = e_wd;
            if (eh) m_last_host = 1; else if (ea) m_last_host = 0;
            if (!bus.host_req || eh) m_wait = 0;
            else if (m_wait < MW)    m_wait++;
            if (bus.host_req && bus.acc_req && m_cnt < 65535) m_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit hr, input bit hw, input int ha, input logic [31:0] hd,
                        input bit ar, input bit aw, input int aa, input logic [31:0] ad,
                        input bit lk);
      bus.host_req = hr; bus.host_we = hw; bus.host_addr = 8'(ha); bus.host_wdata = hd;
      bus.acc_req  = ar; bus.acc_we  = aw; bus.acc_addr  = 8'(aa); bus.acc_wdata  = ad;
      bus.acc_lock = lk;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rst_pulse();
      rst = 1;
      idle();
      tick();
      rst = 0;
   endtask

   initial begin
      idle();
      repeat (3) tick();
      rst = 0;

      // Host-only read of 0x10.
      drive(1, 0, 16, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t1_host_gnt", bus.host_gnt, 1);
      chk("t1_mem_addr", bus.mem_addr, 32'h10);
      tick();
      idle();
      @(negedge clk);
      chk("t1_rvalid", bus.host_rvalid, 1);
      chk("t1_rdata", bus.host_rdata, 32'hDEADBEEF);
      chk("t1_acc_quiet", {bus.acc_rvalid, bus.acc_gnt}, 0);

      // Round-robin after reset: acc first, then alternating.
      tick();
      rst_pulse();
      drive(1, 0, 1, 0, 1, 0, 2, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_acc_gnt", bus.acc_gnt, (i % 2 == 0) ? 1 : 0);
         tick();
      end
      idle();
      @(negedge clk);
      chk("t2_conflict", bus.conflict_cnt, 4);

      // Burst lock against the starvation guard.
      tick();
      rst_pulse();
      drive(1, 0, 3, 0, 1, 0, 4, 0, 1);
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         if (i == 16) chk("t3_host_forced", bus.host_gnt, 1);
         else         chk("t3_acc_locked", bus.acc_gnt, 1);
         tick();
      end
      idle();

      // Accelerator write then host read-back.
      drive(0, 0, 0, 0, 1, 1, 8'h40, 32'h12345678, 0);
      @(negedge clk);
      chk("t4_mem_we", bus.mem_we, 1);
      chk("t4_wdata", bus.mem_wdata, 32'h12345678);
      tick();
      drive(1, 0, 8'h40, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("t4_no_acc_rvalid", bus.acc_rvalid, 0);
      tick();
      idle();
      @(negedge clk);
      chk("t4_host_rdata", bus.host_rdata, 32'h12345678);

      // Reset right after an accelerator read grant.
      tick();
      drive(1, 0, 5, 0, 1, 0, 6, 0, 0);
      tick();
      tick();
      drive(0, 0, 0, 0, 1, 0, 7, 0, 0);
      @(negedge clk);
      chk("t5_acc_gnt", bus.acc_gnt, 1);
      tick();
      rst = 1;
      idle();
      @(negedge clk);
      chk("t5_acc_rvalid", bus.acc_rvalid, 0);
      chk("t5_conflict", bus.conflict_cnt, 0);
      chk("t5_no_gnt", {bus.host_gnt, bus.acc_gnt}, 0);
      tick();
      rst = 0;

      // Random traffic against the model.
      repeat (3000) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom(),
               $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 63), $urandom(),
               $urandom_range(0, 3) == 0);
         tick();
      end
      idle();

      // Conflict counter saturation.
      tick();
      rst_pulse();
      drive(1, 0, 9, 0, 1, 0, 10, 0, 0);
      repeat (65534) tick();
      @(negedge clk);
      chk("t6_fffe", bus.conflict_cnt, 32'hFFFE);
      repeat (3) tick();
      @(negedge clk);
      chk("t6_sat", bus.conflict_cnt, 32'hFFFF);
      tick();
      @(negedge clk);
      chk("t6_hold", bus.conflict_cnt, 32'hFFFF);
      tick();
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
